// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_OVERSAMPLE : default tick pulses per bit period
//   UART_DATA_BITS  : default data bits per frame
//   uart_div()      : baud generator divider for a given clock and baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Rounded f_clk / (UART_OVERSAMPLE * baud), e.g. 50 MHz / 115200 -> 27.
  function automatic int uart_div(input longint f_clk, input longint baud);
    longint den;
    den = longint'(UART_OVERSAMPLE) * baud;
    return int'((f_clk + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
// ---------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is
// defined. Received bytes are offered on a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : receiver enable, low aborts the frame in progress
//   tick        : OVERSAMPLE pulses per bit period from the baud generator
//   rx          : asynchronous serial input, idles high
//   data        : received byte, stable while valid is high
//   valid/ready : output handshake
//   frame_err   : stop bit was low (qualified by valid)
//   parity_err  : even parity mismatch (qualified by valid, 0 without macro)
//   overrun     : one-cycle pulse when a finished byte had to be dropped
//   busy        : FSM not in IDLE
// Configuration macro: UART_RX_PARITY_EN
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 complete;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 par_err_q;
`endif

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // The stop bit is sampled on this tick; the byte is handed over next cycle.
  assign complete = en && tick && (state == STOP) && (cnt == LAST);

`ifdef UART_RX_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Receive FSM plus the output handshake. Completion competes with an
  // acceptance in the same cycle: a free slot (or one being freed) takes the
  // new byte, otherwise the byte is dropped and overrun pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!valid || ready) begin
          data      <= shreg;
          frame_err <= ~rx_s;
          valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
          par_err_q <= par_bad;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
      end else if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          // Re-check the line at mid start bit to reject short glitches.
          START: begin
            if (cnt == MID) begin
              cnt     <= '0;
              bit_idx <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              par_bad <= (^shreg) ^ rx_s;
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx: 50 MHz clock, tick every 27 clocks (x16 of
// ~115200 baud). Parity scenarios are compiled in with UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_DIV  = uart_div(50000000, 115200);
  localparam int BIT_CLKS = CLK_DIV * UART_OVERSAMPLE;

  logic       clk = 1'b0;
  logic       rst_n, en, tick, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  int         div_cnt = 0;
  int         new_cnt = 0;
  int         ovr_cnt = 0;
  int         vhigh   = 0;
  logic       valid_q = 1'b0;
  logic [7:0] last_data = '0;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick       (tick),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Baud generator model: one-clk tick every CLK_DIV clocks, driven off-edge.
  initial tick = 1'b0;
  always @(negedge clk) begin
    if (div_cnt == CLK_DIV - 1) begin
      div_cnt = 0;
      tick    = 1'b1;
    end else begin
      div_cnt = div_cnt + 1;
      tick    = 1'b0;
    end
  end

  // Records every newly presented byte, overrun pulses and valid-high cycles.
  always @(negedge clk) begin
    if (valid && !valid_q) begin
      new_cnt   = new_cnt + 1;
      last_data = data;
      last_ferr = frame_err;
      last_perr = parity_err;
    end
    valid_q = valid;
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (valid) vhigh = vhigh + 1;
  end

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    wait_clks(clks);
  endtask

  // Start, nbits data bits LSB first; the line is left as the last bit.
  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < nbits; i++) send_bit(b[i], BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par,
                            input int stop_clks);
    send_partial(b, 8);
`ifdef UART_RX_PARITY_EN
    send_bit(par, BIT_CLKS);
`else
    if (par) rx = 1'b1;
`endif
    send_bit(stop, stop_clks);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, even_par(b), BIT_CLKS);
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; rx = 1'b1; ready = 1'b1;
    wait_clks(5);
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_err: got %b expected 0", parity_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_basic;
    int n0;
    n0 = new_cnt; vhigh = 0;
    send_good(8'hA5);
    checks++; if (new_cnt !== n0 + 1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected %0d", new_cnt, n0 + 1); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", last_data); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("[TB] FAIL basic_frame_err: got %b expected 0", last_ferr); end
    checks++; if (vhigh !== 1) begin errors++; $display("[TB] FAIL basic_valid_width: got %0d expected 1", vhigh); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", busy); end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = new_cnt;
    send_bit(1'b0, (BIT_CLKS * 3) / 10);
    send_bit(1'b1, 2 * BIT_CLKS);
    checks++; if (new_cnt !== n0) begin errors++; $display("[TB] FAIL glitch_no_valid: got %0d expected %0d", new_cnt, n0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
    send_good(8'h3C);
    checks++; if (new_cnt !== n0 + 1) begin errors++; $display("[TB] FAIL glitch_next_count: got %0d expected %0d", new_cnt, n0 + 1); end
    checks++; if (last_data !== 8'h3C) begin errors++; $display("[TB] FAIL glitch_next_data: got %h expected 3c", last_data); end
  endtask

  task automatic test_frame_err;
    int n0;
    n0 = new_cnt;
    // Stop low for 10 of 16 ticks: long enough to be sampled, short enough
    // that the trailing low is rejected as a false start.
    send_frame(8'h55, 1'b0, even_par(8'h55), 10 * CLK_DIV);
    wait_clks(2 * BIT_CLKS);
    checks++; if (new_cnt !== n0 + 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected %0d", new_cnt, n0 + 1); end
    checks++; if (last_data !== 8'h55) begin errors++; $display("[TB] FAIL ferr_data: got %h expected 55", last_data); end
    checks++; if (last_ferr !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b expected 1", last_ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overrun;
    int n0, o0;
    n0 = new_cnt; o0 = ovr_cnt;
    ready = 1'b0;
    send_good(8'h11);
    checks++; if (new_cnt !== n0 + 1) begin errors++; $display("[TB] FAIL ovr_first_count: got %0d expected %0d", new_cnt, n0 + 1); end
    checks++; if (data !== 8'h11) begin errors++; $display("[TB] FAIL ovr_first_data: got %h expected 11", data); end
    send_good(8'h22);
    checks++; if (ovr_cnt !== o0 + 1) begin errors++; $display("[TB] FAIL ovr_pulses: got %0d expected %0d", ovr_cnt, o0 + 1); end
    checks++; if (data !== 8'h11) begin errors++; $display("[TB] FAIL ovr_data_kept: got %h expected 11", data); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid_held: got %b expected 1", valid); end
    ready = 1'b1;
    wait_clks(2);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_valid_drop: got %b expected 0", valid); end
    send_good(8'h33);
    checks++; if (last_data !== 8'h33) begin errors++; $display("[TB] FAIL ovr_next_data: got %h expected 33", last_data); end
    checks++; if (ovr_cnt !== o0 + 1) begin errors++; $display("[TB] FAIL ovr_next_clean: got %0d expected %0d", ovr_cnt, o0 + 1); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS);
    wait_clks(BIT_CLKS);
    checks++; if (last_data !== 8'h07) begin errors++; $display("[TB] FAIL par_bad_data: got %h expected 07", last_data); end
    checks++; if (last_perr !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_flag: got %b expected 1", last_perr); end
    send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);
    checks++; if (last_perr !== 1'b0) begin errors++; $display("[TB] FAIL par_good_flag: got %b expected 0", last_perr); end
  endtask
`endif

  task automatic test_en_abort;
    int n0;
    ready = 1'b0;
    send_good(8'h5A);
    n0 = new_cnt;
    send_partial(8'h81, 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL en_busy_mid: got %b expected 1", busy); end
    en = 1'b0;
    wait_clks(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL en_idle: got %b expected 0", busy); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL en_valid_held: got %b expected 1", valid); end
    checks++; if (data !== 8'h5A) begin errors++; $display("[TB] FAIL en_data_held: got %h expected 5a", data); end
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    en = 1'b1; ready = 1'b1;
    wait_clks(2);
    send_good(8'hFF);
    checks++; if (new_cnt !== n0 + 1) begin errors++; $display("[TB] FAIL en_next_count: got %0d expected %0d", new_cnt, n0 + 1); end
    checks++; if (last_data !== 8'hFF) begin errors++; $display("[TB] FAIL en_next_data: got %h expected ff", last_data); end
  endtask

  task automatic test_reset_mid;
    int n0;
    send_partial(8'h42, 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy_mid: got %b expected 1", busy); end
    rst_n = 1'b0;
    wait_clks(1);
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_data: got %h expected 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_frame_err: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_parity_err: got %b expected 0", parity_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    rx = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
    n0 = new_cnt;
    send_good(8'hFF);
    checks++; if (new_cnt !== n0 + 1) begin errors++; $display("[TB] FAIL rst_next_count: got %0d expected %0d", new_cnt, n0 + 1); end
    checks++; if (last_data !== 8'hFF) begin errors++; $display("[TB] FAIL rst_next_data: got %h expected ff", last_data); end
  endtask

  initial begin
    $display("[TB] uart_rx bench, clk_div=%0d, bit=%0d clks", CLK_DIV, BIT_CLKS);
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_en_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
